// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and helpers for the LED brightness stage
package led_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_t;

  typedef enum logic {
    MODE_FIXED   = 1'b0,
    MODE_BREATHE = 1'b1
  } led_mode_t;

  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_breathe_pwm_core.sv
// rtl/led_breathe_pwm_core.sv - free-running PWM counter, compare and registered LED output
module led_breathe_pwm_core
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PWM_BITS-1:0] level,
  output logic                led,
  output logic                period_done,
  output logic                boundary
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic [PWM_BITS-1:0] pwm_cnt;

  // High during the last count of a period; the next edge is the period boundary.
  assign boundary = (pwm_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      led         <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      led         <= en & (pwm_cnt < level);
      period_done <= boundary;
    end
  end

endmodule

// File: rtl/led_breathe.sv
// rtl/led_breathe.sv - LED brightness stage: fixed duty or triangle breathing ramp
module led_breathe
  import led_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic                period_done
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(pwm_max(PWM_BITS));
  localparam int                  STEP_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);

  breathe_dir_t        dir;
  logic [STEP_W-1:0]   step_cnt;
  logic                breathing;
  logic                boundary;
  logic [PWM_BITS-1:0] next_level;
  breathe_dir_t        next_dir;

  led_breathe_pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_core (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .level      (level),
    .led        (led),
    .period_done(period_done),
    .boundary   (boundary)
  );

  // The ends of the ramp also cover a stale direction, so level can never wrap.
  always_comb begin
    next_level = level;
    next_dir   = dir;
    if (dir == DIR_UP && level != LEVEL_MAX) begin
      next_level = level + 1'b1;
      next_dir   = (level == LEVEL_MAX - 1'b1) ? DIR_DOWN : DIR_UP;
    end else if (level != '0) begin
      next_level = level - 1'b1;
      next_dir   = (level == {{(PWM_BITS-1){1'b0}}, 1'b1}) ? DIR_UP : DIR_DOWN;
    end else begin
      next_level = level + 1'b1;
      next_dir   = DIR_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level     <= '0;
      dir       <= DIR_UP;
      step_cnt  <= '0;
      breathing <= 1'b0;
    end else if (boundary) begin
      if (led_mode_t'(mode) == MODE_FIXED) begin
        level     <= duty;
        breathing <= 1'b0;
      end else if (!breathing) begin
        breathing <= 1'b1;
        step_cnt  <= '0;
        dir       <= (level == LEVEL_MAX) ? DIR_DOWN : DIR_UP;
      end else if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        level    <= next_level;
        dir      <= next_dir;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_breathe.sv
// tb/tb_led_breathe.sv - self-checking bench for led_breathe against a triangle-wave reference
module tb_led_breathe;

  localparam int BITS = 4;
  localparam int STEP = 2;
  localparam int PER  = 16;
  localparam int MAXL = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            mode = 1'b0;
  logic [BITS-1:0] duty = 4'd8;
  logic            led;
  logic [BITS-1:0] level;
  logic            period_done;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0, m_level = 0, m_led = 0, m_pd = 0;
  int m_breathe = 0, m_start = 0, m_bnd = 0;

  led_breathe #(.PWM_BITS(BITS), .STEP_PERIODS(STEP)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .duty(duty),
    .led(led), .level(level), .period_done(period_done)
  );

  always #5 clk = ~clk;

  function automatic int tri_lvl(input int p);
    int q;
    q = p % (2 * MAXL);
    return (q <= MAXL) ? q : 2 * MAXL - q;
  endfunction

  function automatic int phase();
    return (m_start + m_bnd / STEP) % (2 * MAXL);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed timeout expected event", tag);
  endtask

  // Reference: level is a triangle wave of the number of steps since breathe entry.
  task automatic model_edge();
    if (rst) begin
      m_cnt = 0; m_level = 0; m_led = 0; m_pd = 0; m_breathe = 0;
    end else begin
      m_led = (en && m_cnt < m_level) ? 1 : 0;
      m_pd  = (m_cnt == PER - 1) ? 1 : 0;
      if (m_cnt == PER - 1) begin
        if (!mode) begin
          m_breathe = 0;
          m_level   = int'(duty);
        end else if (!m_breathe) begin
          m_breathe = 1;
          m_start   = m_level;
          m_bnd     = 0;
        end else begin
          m_bnd++;
          m_level = tri_lvl(m_start + m_bnd / STEP);
        end
      end
      m_cnt = (m_cnt + 1) % PER;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("level", 32'(level), 32'(m_level));
    chk("led", 32'(led), 32'(m_led));
    chk("period_done", 32'(period_done), 32'(m_pd));
    if (m_breathe != 0)
      chk("dir", 32'(dut.dir), (phase() >= MAXL) ? 32'd1 : 32'd0);
  endtask

  task automatic sync_pd();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_done && n < 3 * PER);
    if (!period_done) timeout("sync_pd");
  endtask

  task automatic count_period(input string tag, input int exp);
    int hi;
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (led) hi++;
    end
    chk(tag, 32'(hi), 32'(exp));
    chk({tag, "_pd"}, 32'(period_done), 32'd1);
  endtask

  initial begin
    int hi, max_seen, lvl_before, n;

    // Reset held three cycles, then the first period still runs dark.
    rst = 1'b1; en = 1'b1; mode = 1'b0; duty = 4'd8;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rel_level", 32'(level), 32'd0);
    chk("rel_led", 32'(led), 32'd0);
    chk("rel_pd", 32'(period_done), 32'd0);
    sync_pd();
    chk("first_boundary_level", 32'(level), 32'd8);

    duty = 4'd5;
    sync_pd();
    chk("fixed_level", 32'(level), 32'd5);
    repeat (3) count_period("fixed5_highs", 5);

    duty = 4'd0;
    sync_pd();
    repeat (4) count_period("duty0_highs", 0);

    duty = 4'd15;
    sync_pd();
    count_period("duty15_highs", 15);

    hi = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (led) hi++;
      if (i == 4) duty = 4'd3;
    end
    chk("midchange_old_highs", 32'(hi), 32'd15);
    count_period("midchange_new_highs", 3);

    // Breathe from level 0: one full triangle takes 60 periods.
    duty = 4'd0;
    sync_pd();
    mode = 1'b1;
    sync_pd();
    max_seen = 0;
    for (int p = 0; p < 2 * MAXL * STEP; p++) begin
      count_period("breathe_highs", m_level);
      if (int'(level) > max_seen) max_seen = int'(level);
    end
    chk("breathe_max", 32'(max_seen), 32'd15);
    chk("breathe_cycle_end", 32'(level), 32'd0);
    chk("breathe_cycle_dir", 32'(dut.dir), 32'd0);

    // Gated light must not pause the ramp.
    en = 1'b0;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (led) hi++;
    end
    chk("gated_highs", 32'(hi), 32'd0);
    en = 1'b1;
    tick();
    chk("regate_level", 32'(level), 32'(tri_lvl(m_start + m_bnd / STEP)));

    for (int i = 0; i < 600; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) duty = BITS'($urandom);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      tick();
    end

    // Breathe to fixed mid-period.
    en = 1'b1; mode = 1'b1;
    sync_pd();
    sync_pd();
    repeat (7) tick();
    mode = 1'b0; duty = 4'd9;
    lvl_before = int'(level);
    n = 0;
    while (!period_done && n < PER) begin
      chk("switch_hold", 32'(level), 32'(lvl_before));
      tick();
      n++;
    end
    if (!period_done) timeout("switch_pd");
    chk("switch_level", 32'(level), 32'd9);

    // Reset in the middle of a ramp.
    duty = 4'd0;
    sync_pd();
    mode = 1'b1;
    n = 0;
    while (m_level != 7 && n < 2000) begin
      tick();
      n++;
    end
    if (m_level != 7) timeout("wait_level7");
    repeat (3) tick();
    chk("pre_reset_level", 32'(level), 32'd7);
    rst = 1'b1;
    tick();
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_dir", 32'(dut.dir), 32'd0);
    rst = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
